// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
// ---------------
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. The main entry drives the outputs. The skid entry catches the one
// beat that can arrive while the downstream side is stalled. Because the
// upstream ready is a registered decode of the state, dn_ready_in has no
// combinational path to up_ready_out.
//
// Handshake: a beat moves on a rising clk_in when valid and ready are both
// high on that side (push = up_valid_in & up_ready_out, pop = dn_valid_out &
// dn_ready_in). A valid beat is held stable until it is popped, flushed or
// reset.
//
// Optional feature (macro PIPE_SKID_STALL_CNT_EN): adds stall_cnt_out, a
// saturating count of cycles with dn_valid_out & !dn_ready_in, cleared only
// by reset.
//
// Ports:
//   clk_in        rising-edge clock
//   rst_in        synchronous active-high reset (overrides flush/handshake)
//   up_valid_in   upstream beat valid
//   up_ready_out  stage can accept a beat (registered)
//   data_in       upstream data field
//   ctrl_in       upstream control field
//   lsb_clr_in    taken-branch qualifier, clears data bit LSB_CLR_BIT on capture
//   flush_in      squash held beats and any beat offered this cycle
//   dn_valid_out  downstream beat valid
//   dn_ready_in   downstream accepts the beat
//   data_reg_out  data field of the head beat
//   ctrl_reg_out  control field of the head beat (0 after a flush)
//   occ_out       beats held (0..2); also the FSM state encoding
//   stall_cnt_out (PIPE_SKID_STALL_CNT_EN only) saturating stall counter
module pipe_skid_stage #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 16,
  parameter int LSB_CLR_BIT = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              up_valid_in,
  output logic              up_ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              lsb_clr_in,
  input  logic              flush_in,
  output logic              dn_valid_out,
  input  logic              dn_ready_in,
  output logic [DATA_W-1:0] data_reg_out,
  output logic [CTRL_W-1:0] ctrl_reg_out,
  output logic [1:0]        occ_out
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_out
`endif
);

  generate
    if (LSB_CLR_BIT >= DATA_W || LSB_CLR_BIT < 0) begin : g_bad_lsb
      $error("pipe_skid_stage: LSB_CLR_BIT must lie inside data_in");
    end
  endgenerate

  // State encoding equals the occupancy, so occ_out mirrors the FSM state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] main_data, skid_data, cap_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              main_valid, skid_valid;
  logic              push, pop;
  logic              ld_main_in, ld_main_skid, ld_skid;

  assign main_valid   = (state != ST_EMPTY);
  assign skid_valid   = (state == ST_FULL);
  assign up_ready_out = !skid_valid;
  assign dn_valid_out = main_valid;
  assign occ_out      = {1'b0, main_valid} + {1'b0, skid_valid};
  assign data_reg_out = main_data;
  assign ctrl_reg_out = main_ctrl;

  assign push = up_valid_in && up_ready_out;
  assign pop  = dn_valid_out && dn_ready_in;

  // Taken branches produce targets whose LSB must not reach the fetch stage.
  always_comb begin
    cap_data              = data_in;
    cap_data[LSB_CLR_BIT] = data_in[LSB_CLR_BIT] && !lsb_clr_in;
  end

  // Next-state and entry-load decode.
  always_comb begin
    state_next   = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          ld_main_in = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          ld_main_in = 1'b1;
        end else if (push) begin
          ld_skid    = 1'b1;
          state_next = ST_FULL;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          ld_main_skid = 1'b1;
          state_next   = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // Flush discards everything, including a beat offered in the same cycle.
    if (flush_in) begin
      state_next   = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_next;
      if (flush_in) begin
        // Zeroed control keeps write-enables of squashed beats inert;
        // data fields are left as they were.
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (ld_main_in) begin
          main_data <= cap_data;
          main_ctrl <= ctrl_in;
        end else if (ld_main_skid) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end
        if (ld_skid) begin
          skid_data <= cap_data;
          skid_ctrl <= ctrl_in;
        end
      end
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_out <= '0;
    end else if (dn_valid_out && !dn_ready_in && (stall_cnt_out != 16'hFFFF)) begin
      stall_cnt_out <= stall_cnt_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed testbench for pipe_skid_stage (default parameters, LSB_CLR_BIT=0).
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// A scoreboard queue holds accepted beats in order and every pop is checked
// against its head.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              up_valid = 1'b0;
  logic              up_ready;
  logic [DATA_W-1:0] data = '0;
  logic [CTRL_W-1:0] ctrl = '0;
  logic              lsb_clr = 1'b0;
  logic              flush = 1'b0;
  logic              dn_valid;
  logic              dn_ready = 1'b0;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [1:0]        occ;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .LSB_CLR_BIT(0)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .up_valid_in  (up_valid),
    .up_ready_out (up_ready),
    .data_in      (data),
    .ctrl_in      (ctrl),
    .lsb_clr_in   (lsb_clr),
    .flush_in     (flush),
    .dn_valid_out (dn_valid),
    .dn_ready_in  (dn_ready),
    .data_reg_out (data_reg),
    .ctrl_reg_out (ctrl_reg),
    .occ_out      (occ)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt_out(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the currently driven inputs; scoreboard updates first.
  task automatic tick();
    logic [DATA_W-1:0] d;
    if (dn_valid && dn_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'(data_reg), 32'hxxxx_xxxx);
      else check("pop_order", 32'(data_reg), 32'(exp_q.pop_front()));
    end
    if (rst || flush) begin
      exp_q.delete();
    end else if (up_valid && up_ready) begin
      d = data;
      if (lsb_clr) d[0] = 1'b0;
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input logic lc);
    up_valid = 1'b1;
    data     = d;
    ctrl     = c;
    lsb_clr  = lc;
  endtask

  task automatic idle();
    up_valid = 1'b0;
    lsb_clr  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] rdy_pat;

  initial begin
    #1;
    do_reset();
    check("rst_dn_valid", 32'(dn_valid), 32'd0);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_up_ready", 32'(up_ready), 32'd1);
    check("rst_data", 32'(data_reg), 32'd0);
    check("rst_ctrl", 32'(ctrl_reg), 32'd0);

    // streaming at full rate
    dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h10 + i, 16'(i + 1), 1'b0);
      tick();
      check("stream_valid", 32'(dn_valid), 32'd1);
      check("stream_occ", 32'(occ), 32'd1);
      check("stream_data", 32'(data_reg), 32'h10 + i);
      check("stream_ctrl", 32'(ctrl_reg), 32'(i + 1));
    end
    idle();
    tick();
    check("stream_drain_occ", 32'(occ), 32'd0);
    check("stream_drain_valid", 32'(dn_valid), 32'd0);

    // back-pressure into the skid entry
    dn_ready = 1'b0;
    offer(32'hA0, 16'h1, 1'b0);
    tick();
    check("bp_occ1", 32'(occ), 32'd1);
    check("bp_ready1", 32'(up_ready), 32'd1);
    offer(32'hA1, 16'h2, 1'b0);
    tick();
    check("bp_occ2", 32'(occ), 32'd2);
    check("bp_ready0", 32'(up_ready), 32'd0);
    offer(32'hA2, 16'h3, 1'b0);
    tick();
    check("bp_hold_occ", 32'(occ), 32'd2);
    check("bp_hold_head", 32'(data_reg), 32'hA0);
    dn_ready = 1'b1;
    tick();
    check("bp_rel_head", 32'(data_reg), 32'hA1);
    check("bp_rel_occ", 32'(occ), 32'd1);
    check("bp_rel_ready", 32'(up_ready), 32'd1);
    tick();
    check("bp_a2_head", 32'(data_reg), 32'hA2);
    check("bp_a2_ctrl", 32'(ctrl_reg), 32'h3);
    idle();
    tick();
    check("bp_empty", 32'(occ), 32'd0);

    // LSB clear on capture
    dn_ready = 1'b0;
    offer(32'h1235, 16'h7, 1'b1);
    tick();
    check("lsb_clr_on", 32'(data_reg), 32'h1234);
    dn_ready = 1'b1;
    offer(32'h1235, 16'h7, 1'b0);
    tick();
    check("lsb_clr_off", 32'(data_reg), 32'h1235);
    offer(32'h8000_0003, 16'h7, 1'b1);
    tick();
    check("lsb_clr_hi", 32'(data_reg), 32'h8000_0002);
    idle();
    tick();
    check("lsb_empty", 32'(occ), 32'd0);

    // flush in FULL with a beat offered
    dn_ready = 1'b0;
    offer(32'hB0, 16'h00FF, 1'b0);
    tick();
    offer(32'hB1, 16'h00FF, 1'b0);
    tick();
    check("fl_full_occ", 32'(occ), 32'd2);
    check("fl_full_ctrl", 32'(ctrl_reg), 32'h00FF);
    offer(32'hB2, 16'h00FF, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_valid", 32'(dn_valid), 32'd0);
    check("fl_occ", 32'(occ), 32'd0);
    check("fl_ctrl", 32'(ctrl_reg), 32'd0);
    check("fl_ready", 32'(up_ready), 32'd1);
    check("fl_data_kept", 32'(data_reg), 32'hB0);
    dn_ready = 1'b1;
    tick();
    tick();
    check("fl_no_beat", 32'(dn_valid), 32'd0);

    // flush in ONE with a concurrent pop and an acceptable push
    offer(32'hC0, 16'h11, 1'b0);
    tick();
    offer(32'hC1, 16'h22, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl1_occ", 32'(occ), 32'd0);
    check("fl1_ctrl", 32'(ctrl_reg), 32'd0);
    tick();
    check("fl1_no_beat", 32'(dn_valid), 32'd0);

    // fixed ready pattern with continuous offering
    rdy_pat = 16'b1011_0010_1100_0110;
    for (int i = 0; i < 16; i++) begin
      dn_ready = rdy_pat[i];
      offer(32'hD0 + i, 16'(i), 1'b0);
      tick();
    end
    idle();
    dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("pat_drained_occ", 32'(occ), 32'd0);
    check("pat_q_empty", 32'(exp_q.size()), 32'd0);

    // reset mid-operation overriding flush and push
    dn_ready = 1'b0;
    offer(32'hE0, 16'h5A, 1'b0);
    tick();
    offer(32'hE1, 16'h5A, 1'b0);
    tick();
    check("rm_occ2", 32'(occ), 32'd2);
    offer(32'hE2, 16'h5A, 1'b0);
    flush = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    idle();
    check("rm_valid", 32'(dn_valid), 32'd0);
    check("rm_occ", 32'(occ), 32'd0);
    check("rm_data", 32'(data_reg), 32'd0);
    check("rm_ctrl", 32'(ctrl_reg), 32'd0);
    check("rm_ready", 32'(up_ready), 32'd1);

`ifdef PIPE_SKID_STALL_CNT_EN
    check("sc_reset", 32'(stall_cnt), 32'd0);
    dn_ready = 1'b0;
    offer(32'hF0, 16'h1, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    check("sc_five", 32'(stall_cnt), 32'd5);
    dn_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sc_after_flush", 32'(stall_cnt), 32'd5);
    dn_ready = 1'b0;
    offer(32'hF1, 16'h1, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
    end
    #1;
    check("sc_saturate", 32'(stall_cnt), 32'hFFFF);
    do_reset();
    check("sc_rst_clear", 32'(stall_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register between two pipeline stages, replacing the fixed-width, always-advancing stage registers.
- Adds a valid/ready handshake, a 2-entry skid buffer so back-pressure never drops a beat, synchronous flush, and optional clearing of the target LSB on a taken branch.
- Payload is split into a data field and a control field. Flush zeroes the control field so write-enables cannot fire on squashed beats.

Parameters:
- DATA_W, 32, width of the data field (rs1/rs2/pc/imm bundle, packed by the instantiator).
- CTRL_W, 16, width of the control field (alu opcode, load size, wb mux select, rf write enable, ...).
- LSB_CLR_BIT, 0, bit index within data_in that lsb_clr_in forces to 0 on capture.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- up_valid_in  input  1  upstream beat valid.
- up_ready_out  output  1  stage can accept a beat this cycle.
- data_in  input  DATA_W  upstream data field.
- ctrl_in  input  CTRL_W  upstream control field.
- lsb_clr_in  input  1  taken-branch qualifier; clears data bit LSB_CLR_BIT of the captured beat.
- flush_in  input  1  squash all held beats and any beat offered this cycle.
- dn_valid_out  output  1  downstream beat valid.
- dn_ready_in  input  1  downstream accepts the beat.
- data_reg_out  output  DATA_W  registered data field of the head beat.
- ctrl_reg_out  output  CTRL_W  registered control field of the head beat.
- occ_out  output  2  number of beats held: 0, 1 or 2.

Behaviour:
- Push = up_valid_in && up_ready_out. Pop = dn_valid_out && dn_ready_in. All state updates on rising clk_in.
- Storage: main entry (drives the outputs) and skid entry. Each entry is a data field, a control field and a valid bit.
- up_ready_out = !skid_valid. It is a register output, with no combinational path from dn_ready_in.
- dn_valid_out = main_valid. occ_out = main_valid + skid_valid.
- Capture transform: the stored data equals data_in, except bit LSB_CLR_BIT = data_in[LSB_CLR_BIT] && !lsb_clr_in. The control field is stored unchanged.
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
- EMPTY:
  - Push: main <= input, go to ONE.
  - Otherwise: stay in EMPTY.
- ONE:
  - Push and pop: main <= input, stay in ONE.
  - Push only: skid <= input, go to FULL.
  - Pop only: go to EMPTY.
  - Neither: hold.
- FULL (up_ready_out = 0, no push possible):
  - Pop: main <= skid, skid invalid, go to ONE.
  - Otherwise: hold.
- Ordering: beats leave strictly in acceptance order; none is duplicated or dropped.
- Latency: 1 cycle from push into EMPTY to dn_valid_out = 1. Sustained throughput is 1 beat/cycle while dn_ready_in = 1.
- Flush (flush_in = 1, rst_in = 0):
  - Next state is EMPTY and both valid bits clear.
  - A beat pushed in the same cycle is discarded.
  - Both control fields are zeroed; data fields keep their values.
  - A pop asserted in the same cycle completes from the downstream view (the beat was presented); no further beat follows.
- Reset (rst_in = 1): overrides flush and the handshake.
  - Next cycle: every entry field is 0, dn_valid_out = 0, data_reg_out = 0, ctrl_reg_out = 0, occ_out = 0, up_ready_out = 1.
  - Reset asserted mid-stream drops held beats without popping them.
- Outputs while dn_valid_out = 0: data_reg_out and ctrl_reg_out hold their last values and carry no meaning. After a flush, ctrl_reg_out reads 0.
- Width rule: the LSB clear applies to a single bit only. Elaboration requires LSB_CLR_BIT < DATA_W.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt_out, 16 bits.
  - Increments each cycle dn_valid_out && !dn_ready_in, saturating at 16'hFFFF.
  - Cleared only by rst_in; flush does not clear it.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset then stream: rst_in=1 for 2 cycles, then push data 0x00000010..0x00000013 on consecutive cycles with dn_ready_in=1 -> dn_valid_out rises 1 cycle after the first push, same values out in order, occ_out stays 1.
- Back-pressure: push 0xA0, 0xA1, 0xA2 on consecutive cycles with dn_ready_in=0 -> occ_out goes 1 then 2, up_ready_out=0 after 0xA1 is accepted, 0xA2 is held off by up_ready_out=0 (not lost), then release dn_ready_in -> 0xA0, 0xA1, 0xA2 out in order, no loss.
- LSB clear: push data 0x00001235 with lsb_clr_in=1 (LSB_CLR_BIT=0) -> data_reg_out=0x00001234; same push with lsb_clr_in=0 -> 0x00001235.
- Flush in FULL with a concurrent push: ctrl held = 0x00FF, flush_in=1 -> next cycle dn_valid_out=0, occ_out=0, ctrl_reg_out=0, up_ready_out=1, the pushed beat never appears.
- Reset mid-operation: occ_out=2, assert rst_in together with flush_in and up_valid_in -> all outputs 0 and up_ready_out=1 next cycle.
- With PIPE_SKID_STALL_CNT_EN: hold dn_valid_out=1 with dn_ready_in=0 for 5 cycles -> stall_cnt_out=5; a subsequent flush leaves it at 5; force 70000 stall cycles -> saturates at 0xFFFF.
